// File: rtl/script_dump_tx_pkg.sv
// Shared types and widths for the script dump path.
// No logic; constants only.
// Default widths match the script memory block.
package script_dump_tx_pkg;

  localparam int BYTE_W        = 8;
  localparam int SCRIPT_WORD_W = 16;
  localparam int SCRIPT_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WAIT,
    SEND,
    END
  } state_t;

endpackage

// File: rtl/script_dump_tx_byte_serializer.sv
// Parallel word load, byte-wide valid/ready output, most-significant byte first.
// Latency: first byte is valid the cycle after load.
// Backpressure: holds the current byte and valid while ready is low.
module byte_serializer
  import script_dump_tx_pkg::*;
#(
  parameter int WORD_W = SCRIPT_WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              ready,
  output logic              valid,
  output logic [BYTE_W-1:0] bits,
  output logic              last
);

  localparam int NB    = WORD_W / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;

  assign bits = shreg[WORD_W-1 -: BYTE_W];
  assign last = (idx == IDX_W'(NB - 1));

  // Load a fresh word, or shift out one byte per accepted transfer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= word;
      idx   <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (last) begin
        shreg <= '0;
        idx   <= '0;
        valid <= 1'b0;
      end else begin
        shreg <= shreg << BYTE_W;
        idx   <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/script_dump_tx.sv
// Walks script memory from address 0 and streams an optional count header plus every word as bytes.
// Latency: header the cycle after start; then max(READ_LAT,1) fetch cycles plus one cycle per byte per word.
// Backpressure: tx_ready low freezes state, pc, word register and tx outputs.
module script_dump_tx
  import script_dump_tx_pkg::*;
#(
  parameter int WORD_W    = SCRIPT_WORD_W,
  parameter int ADDR_W    = SCRIPT_ADDR_W,
  parameter int READ_LAT  = 1,
  parameter int HEADER_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              script_mode,
  input  logic [ADDR_W-1:0] script_num,
  input  logic [WORD_W-1:0] script,
  output logic [ADDR_W-1:0] pc,
  output logic [BYTE_W-1:0] tx_bits,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  // A zero-latency memory still gets one WAIT cycle so the fetch has a slot.
  localparam int WAIT_CYC = (READ_LAT < 1) ? 1 : READ_LAT;
  localparam int LAT_W    = 2;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] num;
  logic [LAT_W-1:0]  lat_cnt;
  logic              accept;
  logic              word_load;
  logic              last_word;
  logic              ser_vld;
  logic              ser_last;
  logic              ser_xfer;
  logic [BYTE_W-1:0] ser_byte;

  assign last_word = (pc == (num - ADDR_W'(1)));
  assign ser_xfer  = ser_vld && tx_ready;

  // Header byte comes straight from the latched count; word bytes from the serializer.
  assign tx_valid = (state == HDR) || ser_vld;
  assign tx_bits  = (state == HDR) ? BYTE_W'(num) : ser_byte;

  byte_serializer #(
    .WORD_W(WORD_W)
  ) u_ser (
    .clock(clock),
    .reset(reset),
    .load (word_load),
    .word (script),
    .ready(tx_ready),
    .valid(ser_vld),
    .bits (ser_byte),
    .last (ser_last)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus busy/done and the accept/load strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    word_load = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && script_mode) begin
          accept = 1'b1;
          if (HEADER_EN != 0)        state_nxt = HDR;
          else if (script_num == '0) state_nxt = END;
          else                       state_nxt = WAIT;
        end
      end
      HDR: begin
        busy = 1'b1;
        if (tx_ready) state_nxt = (num == '0) ? END : WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_cnt == LAT_W'(WAIT_CYC - 1)) begin
          word_load = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        busy = 1'b1;
        if (ser_xfer && ser_last) state_nxt = last_word ? END : WAIT;
      end
      END: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Count latch, read address and fetch-latency counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      num     <= '0;
      pc      <= '0;
      lat_cnt <= '0;
    end else begin
      if (accept) begin
        num <= script_num;
        pc  <= '0;
      end
      if (state == WAIT) begin
        lat_cnt <= word_load ? '0 : lat_cnt + LAT_W'(1);
      end
      if (state == SEND && ser_xfer && ser_last && !last_word) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

endmodule

// File: doc/script_dump_tx.md
Name: script_dump_tx

Overview:
- Read-side counterpart of the script memory: walks the stored script by driving `pc` and fetching 16-bit `script` words.
- Serialises each word into bytes on a valid/ready byte stream toward the UART transmitter.
- Lets the host read back and verify what it downloaded.
- Sits between the script memory's read port and the UART TX byte interface.

Parameters:
- WORD_W, 16, script word width; must be a multiple of 8.
- ADDR_W, 8, width of `pc` and `script_num`.
- READ_LAT, 1, cycles from a `pc` change to a valid `script` word; allowed range 0..3.
- HEADER_EN, 1, when 1 send `script_num` as a header byte before the words.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump.
- script_mode  in  1  script memory holds a loaded script; `start` is accepted only when this is 1.
- script_num  in  ADDR_W  number of stored words; sampled on the accepted `start`.
- script  in  WORD_W  memory read data at `pc`.
- pc  out  ADDR_W  memory read address.
- tx_bits  out  8  byte to transmit.
- tx_valid  out  1  `tx_bits` is valid.
- tx_ready  in  1  transmitter accepts the byte.
- busy  out  1  a dump is in progress.
- done  out  1  one-cycle pulse when the last byte has transferred.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, pc=0, tx_bits=0, tx_valid=0, busy=0, done=0, word and byte counters=0. Reset mid-dump aborts immediately; the partial stream is not resumed.
- Handshake: a byte transfers on an edge where tx_valid&&tx_ready. Once tx_valid rises, tx_bits and tx_valid hold until that transfer. tx_valid never depends combinationally on tx_ready.
- States:
  - IDLE: busy=0. On start&&script_mode: latch num=script_num, set pc=0, busy=1. Go to HDR if HEADER_EN, else go to WAIT (or END if num==0). start while script_mode==0 is ignored.
  - HDR: tx_valid=1, tx_bits=num. On transfer: if num==0 go to END, else go to WAIT.
  - WAIT: count READ_LAT cycles with pc stable, then latch `script` into the word register and go to SEND. With READ_LAT=0, latch in the same cycle WAIT is entered and spend one cycle in WAIT.
  - SEND: emit WORD_W/8 bytes, most-significant byte first, one per transfer. After the last byte: if pc==num-1 go to END, else pc<=pc+1 and go to WAIT.
  - END: done=1 for exactly one cycle, busy=0, return to IDLE.
- start while busy is ignored. Inputs script_num and script_mode are ignored during a dump; the latched num governs.
- pc never wraps: the maximum num is 2^ADDR_W-1, so the last address is num-1.
- Throughput with tx_ready held 1, READ_LAT=1, HEADER_EN=1: header at cycle 1 after start, then 3 cycles per 16-bit word (WAIT, HI, LO). done is asserted in the cycle after the final transfer.
- Backpressure: tx_ready low stalls in HDR or SEND indefinitely with outputs stable. pc and the word register do not change while stalled.

Decomposition:
- Shared package holds:
  - state enum {IDLE, HDR, WAIT, SEND, END};
  - the byte width constant 8;
  - the default WORD_W and ADDR_W, shared with the script memory block.
- One natural sub-module, `byte_serializer`: parallel WORD_W load plus valid/ready byte output, MSB first, with a last-byte flag.
- The FSM, pc counter and latency counter stay in the top module.

Test Plan:
- Basic dump: memory = {0x0A0D, 0x6000}, script_num=2, script_mode=1, tx_ready=1, pulse start. Expect bytes 0x02, 0x0A, 0x0D, 0x60, 0x00 on consecutive valid cycles except one WAIT gap per word, pc sequence 0 then 1, and one done pulse 1 cycle after byte 0x00.
- Backpressure: same memory, tx_ready toggled 1,0,0,1 pseudo-randomly. Expect the same byte sequence, tx_bits stable while tx_valid&&!tx_ready, and no byte dropped or duplicated.
- Empty script: script_num=0. Expect a single byte 0x00 then done. pc stays 0 and no word is read.
- Gating: start with script_mode=0 gives no tx_valid and busy stays 0. A second start during a dump is ignored; the stream stays identical to the basic dump.
- Reset mid-dump: assert reset low after byte 0x0A transfers. At the next edge expect tx_valid=0, busy=0, pc=0. A fresh start then produces the full sequence from 0x02.
- Max count: script_num=255 with word i = {i, ~i}. Expect 511 bytes, pc ending at 254, and no wrap to 0 before done.
